// File: rtl/freq_div_cfg_loader.sv
// Configuration sequencer for the adjustable frequency divider: accepts a
// (period, duty) request, validates it and loads both values in an order the divider accepts.
module freq_div_cfg_loader #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_period,
  input  logic [WIDTH-1:0] req_duty,
  output logic             ld_p,
  output logic             ld_d,
  output logic [WIDTH-1:0] par_load,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] cur_period,
  output logic [WIDTH-1:0] cur_duty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD1,
    S_LD2,
    S_SETTLE,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_req_period;
  logic [WIDTH-1:0] r_req_duty;
  logic             r_period_first;
  logic [3:0]       r_cnt;
  logic             r_ld_p;
  logic             r_ld_d;
  logic [WIDTH-1:0] r_par_load;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_cur_period;
  logic [WIDTH-1:0] r_cur_duty;

  logic w_accept;
  logic w_req_ok;
  logic w_period_first;

  assign w_accept       = req_valid && (r_state == S_IDLE);
  assign w_req_ok       = (req_period >= WIDTH'(2)) && (req_duty <= req_period);
  // Loading period first is safe only if it is not below the duty the divider currently holds.
  assign w_period_first = (req_period >= r_cur_duty);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_req_period   <= '0;
      r_req_duty     <= '0;
      r_period_first <= 1'b0;
      r_cnt          <= '0;
      r_ld_p         <= 1'b0;
      r_ld_d         <= 1'b0;
      r_par_load     <= '0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_cur_period   <= '0;
      r_cur_duty     <= '0;
    end else begin
      r_ld_p     <= 1'b0;
      r_ld_d     <= 1'b0;
      r_par_load <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;

      // Shadows follow the divider: they take a value on the edge that ends its strobe.
      if (r_ld_p) r_cur_period <= r_par_load;
      if (r_ld_d) r_cur_duty   <= r_par_load;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_period <= req_period;
            r_req_duty   <= req_duty;
            if (w_req_ok) begin
              r_period_first <= w_period_first;
              r_state        <= S_LD1;
              if (w_period_first) begin
                r_ld_p     <= 1'b1;
                r_par_load <= req_period;
              end else begin
                r_ld_d     <= 1'b1;
                r_par_load <= req_duty;
              end
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        S_LD1: begin
          r_state <= S_LD2;
          if (r_period_first) begin
            r_ld_d     <= 1'b1;
            r_par_load <= r_req_duty;
          end else begin
            r_ld_p     <= 1'b1;
            r_par_load <= r_req_period;
          end
        end
        S_LD2: begin
          if (SETTLE_CYCLES == 0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_SETTLE;
            r_cnt   <= 4'(SETTLE_CYCLES - 1);
          end
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign ld_p       = r_ld_p;
  assign ld_d       = r_ld_d;
  assign par_load   = r_par_load;
  assign done       = r_done;
  assign err        = r_err;
  assign cur_period = r_cur_period;
  assign cur_duty   = r_cur_duty;

endmodule
